load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Groups the request/response handshake and the data-memory port of the
// load/store unit into one bundle.
//   slave  : the LSU side (takes requests, drives responses and the memory port)
//   master : the requester + data memory side
// Signals:
//   req_valid/req_ready, req_write, req_op[2:0], req_addr[31:0], req_wdata[31:0]
//   resp_valid/resp_ready, resp_data[31:0], resp_err
//   mem_address[31:0], mem_writeEnable, mem_dataIn[31:0], mem_dataOut[31:0]
`timescale 1ns/1ps
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_writeEnable;
    logic [31:0] mem_dataIn;
    logic [31:0] mem_dataOut;

    modport slave (
        input  req_valid, req_write, req_op, req_addr, req_wdata,
        input  resp_ready, mem_dataOut,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_address, mem_writeEnable, mem_dataIn
    );

    modport master (
        output req_valid, req_write, req_op, req_addr, req_wdata,
        output resp_ready, mem_dataOut,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_address, mem_writeEnable, mem_dataIn
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Byte/half/word load-store unit in front of a word-wide synchronous data
// memory (one-cycle read latency). Sub-word stores are done as
// read-modify-write.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : load_store_unit_if.slave (request, response, memory port)
// Parameter:
//   MEM_WORDS : memory depth in 32-bit words; word index wraps modulo depth
// Build option:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned H/HU/W requests skip the
//   memory and respond with resp_err=1, resp_data=0. When undefined,
//   resp_err is tied 0 and the low address bits below the access size are
//   ignored.
// op encoding: [1:0] 00 B, 01 H, 1x W; [2] = zero-extend (loads only).
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    // Holds the store data from accept, then the merged word for B/H stores.
    logic [31:0] data_q, data_d;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic        req_misaligned;
    logic [29:0] word_idx;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (bus.req_op[1:0])
            2'b00:   req_misaligned = 1'b0;
            2'b01:   req_misaligned = bus.req_addr[0];
            default: req_misaligned = |bus.req_addr[1:0];
        endcase
    end

    logic err_q, err_d;
    assign err_d = accept ? req_misaligned : err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign req_misaligned = 1'b0;
    assign bus.resp_err   = 1'b0;
`endif

    assign word_idx = addr_q[31:2] % 30'(MEM_WORDS);

    // Lane extraction from the word returned by memory (little-endian).
    assign lane_b = bus.mem_dataOut[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h = addr_q[1] ? bus.mem_dataOut[31:16] : bus.mem_dataOut[15:0];

    always_comb begin
        case (op_q[1:0])
            2'b00:   load_val = op_q[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = op_q[2] ? {16'h0000, lane_h}   : {{16{lane_h[15]}}, lane_h};
            default: load_val = bus.mem_dataOut;
        endcase
    end

    always_comb begin
        merged = bus.mem_dataOut;
        case (op_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merged = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_wdata;
                    rdata_d = '0;
                    if (req_misaligned) begin
                        state_d = S_RESP;
                    end else if (bus.req_write && bus.req_op[1]) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:    state_d = S_MERGE;
            S_MERGE: begin
                if (write_q) begin
                    data_d  = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_val;
                    state_d = S_RESP;
                end
            end
            S_WR:    state_d = S_RESP;
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            op_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.req_ready       = (state_q == S_IDLE) && reset_n;
    assign bus.resp_valid      = (state_q == S_RESP);
    assign bus.resp_data       = rdata_q;
    assign bus.mem_address     = {2'b00, word_idx};
    // Gated by reset_n so a write can never land while reset is asserted.
    assign bus.mem_writeEnable = (state_q == S_WR) && reset_n;
    assign bus.mem_dataIn      = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit with a behavioural synchronous
// data memory. Expected responses are queued when a request is driven and
// compared when the response appears.
`timescale 1ns/1ps
module tb_load_store_unit;
    localparam int unsigned MEM_WORDS = 1024;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Data memory: synchronous read, one-cycle latency.
    logic [31:0] mem [MEM_WORDS];
    int we_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_writeEnable) begin
            mem[bus.mem_address[9:0]] <= bus.mem_dataIn;
            we_cnt <= we_cnt + 1;
        end
        bus.mem_dataOut <= mem[bus.mem_address[9:0]];
    end

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   miscmp  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one request starting at a negedge and completes its response.
    // exp_lat counts rising edges from the accept edge (inclusive) to the
    // edge after which resp_valid is seen. hold = cycles resp_ready stays low
    // in RESP while a competing request is offered.
    task automatic do_req(input logic wr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input int exp_we,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int hold);
        int   n;
        int   we0;
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        bus.req_write = wr;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        we0 = we_cnt;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mem_address", bus.mem_address, 32'((addr >> 2) % MEM_WORDS));
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exp_lat));
        e = sb_q.pop_front();
        chk("resp_data", bus.resp_data, e.data);
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_op    = OP_W;
            bus.req_addr  = addr;
            bus.req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("hold_data", bus.resp_data, e.data);
            chk("hold_err", 32'(bus.resp_err), 32'(e.err));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_done", 32'(bus.resp_valid), 32'd0);
        chk("we_count", 32'(we_cnt - we0), 32'(exp_we));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_op     = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_writeEnable), 32'd0);
        chk("rst_mem_din", bus.mem_dataIn, 32'd0);
        chk("rst_mem_addr", bus.mem_address, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store/load
        do_req(1, OP_W,  32'h10, 32'hDEADBEEF, 2, 1, 32'h0, 0, 0);
        do_req(0, OP_W,  32'h10, 32'h0,        3, 0, 32'hDEADBEEF, 0, 0);
        // Byte store, then loads with sign/zero extension
        do_req(1, OP_B,  32'h11, 32'hA5A5A555, 4, 1, 32'h0, 0, 0);
        do_req(0, OP_W,  32'h10, 32'h0,        3, 0, 32'hDEAD55EF, 0, 0);
        do_req(0, OP_B,  32'h13, 32'h0,        3, 0, 32'hFFFFFFDE, 0, 0);
        do_req(0, OP_BU, 32'h13, 32'h0,        3, 0, 32'h000000DE, 0, 0);
        // Half store, then loads
        do_req(1, OP_H,  32'h12, 32'h12348001, 4, 1, 32'h0, 0, 0);
        do_req(0, OP_H,  32'h12, 32'h0,        3, 0, 32'hFFFF8001, 0, 0);
        do_req(0, OP_HU, 32'h12, 32'h0,        3, 0, 32'h00008001, 0, 0);
        do_req(0, OP_W,  32'h10, 32'h0,        3, 0, 32'h800155EF, 0, 0);
        do_req(0, OP_H,  32'h10, 32'h0,        3, 0, 32'h000055EF, 0, 0);
        do_req(0, OP_B,  32'h10, 32'h0,        3, 0, 32'hFFFFFFEF, 0, 0);
        // op[1:0]=11 is a word; op[2] ignored for stores
        do_req(0, 3'b011, 32'h10, 32'h0,       3, 0, 32'h800155EF, 0, 0);
        do_req(1, OP_BU, 32'h10, 32'h00000080, 4, 1, 32'h0, 0, 0);
        do_req(0, OP_B,  32'h10, 32'h0,        3, 0, 32'hFFFFFF80, 0, 0);
        // Word index wraps modulo MEM_WORDS: 0x1020 aliases 0x20
        do_req(1, 3'b111, 32'h1020, 32'hCAFEF00D, 2, 1, 32'h0, 0, 0);
        do_req(0, OP_W,  32'h20, 32'h0,        3, 0, 32'hCAFEF00D, 0, 0);
        // Response back-pressure with a competing request offered
        do_req(0, OP_W,  32'h20, 32'h0,        3, 0, 32'hCAFEF00D, 0, 5);
        do_req(0, OP_W,  32'h20, 32'h0,        3, 0, 32'hCAFEF00D, 0, 0);

        // Reset while a byte store sits in WR
        chk("pre_sb_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_op    = OP_B;
        bus.req_addr  = 32'h21;
        bus.req_wdata = 32'h000000AA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_state_we", 32'(bus.mem_writeEnable), 32'd1);
        we0 = we_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(bus.mem_writeEnable), 32'd0);
        chk("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mid_din", bus.mem_dataIn, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_no_write", 32'(we_cnt - we0), 32'd0);
        do_req(0, OP_W,  32'h20, 32'h0,        3, 0, 32'hCAFEF00D, 0, 0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(0, OP_W,  32'h13, 32'h0,        1, 0, 32'h0, 1, 0);
        do_req(1, OP_H,  32'h11, 32'h00001234, 1, 0, 32'h0, 1, 0);
        do_req(0, OP_B,  32'h13, 32'h0,        3, 0, 32'hFFFFFF80, 0, 0);
`else
        do_req(0, OP_W,  32'h13, 32'h0,        3, 0, 32'h80015580, 0, 0);
        do_req(0, OP_H,  32'h11, 32'h0,        3, 0, 32'h00005580, 0, 0);
`endif
        do_req(0, OP_W,  32'h10, 32'h0,        3, 0, 32'h80015580, 0, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end
endmodule
